// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states, instruction classes and datapath select encodings
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_ILL
   } class_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_PASSB = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_BR    = 2'b11;

   localparam logic [1:0] A_RS1  = 2'b00;
   localparam logic [1:0] A_PC   = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
endpackage

// File: rtl/riscv_opcode_class.sv
// riscv_opcode_class: maps an RV32I opcode to its instruction class and a legal flag
module riscv_opcode_class
   import riscv_ctrl_pkg::*;
#(
   parameter int ENABLE_EXT = 1
) (
   input  logic [6:0] opcode_i,
   output class_e     cls_o,
   output logic       legal_o
);
   // AUIPC/JALR collapse to the illegal class when the extension is off
   always_comb begin
      cls_o = CL_ILL;
      case (opcode_i)
         OP_R:      cls_o = CL_R;
         OP_I:      cls_o = CL_I;
         OP_LOAD:   cls_o = CL_LOAD;
         OP_STORE:  cls_o = CL_STORE;
         OP_LUI:    cls_o = CL_LUI;
         OP_AUIPC:  cls_o = ENABLE_EXT != 0 ? CL_AUIPC : CL_ILL;
         OP_JAL:    cls_o = CL_JAL;
         OP_JALR:   cls_o = ENABLE_EXT != 0 ? CL_JALR : CL_ILL;
         OP_BRANCH: cls_o = CL_BRANCH;
         default:   cls_o = CL_ILL;
      endcase
      legal_o = cls_o != CL_ILL;
   end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle RV32I control FSM with memory handshakes and traps
module riscv_multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int ENABLE_EXT     = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       branch,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] wb_sel,
   output logic       illegal_instr,
   output logic       mem_timeout,
   output logic [2:0] state_o
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

   state_e          state_q, state_d;
   class_e          class_q, class_d, dec_cls;
   logic            dec_legal;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ill_q, ill_d, to_q, to_d;
   logic            limit;

   riscv_opcode_class #(.ENABLE_EXT(ENABLE_EXT)) u_class (
      .opcode_i (opcode),
      .cls_o    (dec_cls),
      .legal_o  (dec_legal)
   );

   assign limit         = (TIMEOUT_CYCLES > 0) && (cnt_q == LIMIT);
   assign illegal_instr = ill_q & ~rst;
   assign mem_timeout   = to_q & ~rst;
   assign state_o       = state_q;

   // state, class, wait counter and sticky trap flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         class_q <= CL_R;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         to_q    <= to_d;
      end
   end

   // next state plus Moore strobes; the wait counter only survives while a wait state repeats
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      cnt_d     = '0;
      ill_d     = ill_q;
      to_d      = to_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
      alu_src_a = A_RS1;
      alu_src_b = B_RS2;
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      case (state_q)
         S_FETCH: begin
            imem_req  = 1'b1;
            alu_src_a = A_PC;
            alu_src_b = B_FOUR;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (limit) begin
               state_d = S_TRAP;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            class_d = dec_cls;
            state_d = dec_legal ? S_EXEC : S_TRAP;
            ill_d   = ill_q | ~dec_legal;
         end
         S_EXEC: begin
            state_d = S_WB;
            case (class_q)
               CL_R:              alu_op = ALU_FUNCT;
               CL_I: begin
                  alu_src_b = B_IMM;
                  alu_op    = ALU_FUNCT;
               end
               CL_LOAD, CL_STORE: begin
                  alu_src_b = B_IMM;
                  state_d   = S_MEM;
               end
               CL_LUI: begin
                  alu_src_a = A_ZERO;
                  alu_src_b = B_IMM;
                  alu_op    = ALU_PASSB;
               end
               CL_AUIPC, CL_JAL: begin
                  alu_src_a = A_PC;
                  alu_src_b = B_IMM;
               end
               CL_JALR:           alu_src_b = B_IMM;
               CL_BRANCH: begin
                  alu_op  = ALU_BR;
                  branch  = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  state_d = S_TRAP;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = class_q == CL_STORE;
            if (dmem_ready) begin
               state_d = class_q == CL_STORE ? S_FETCH : S_WB;
            end else if (limit) begin
               state_d = S_TRAP;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = class_q == CL_LOAD ? WB_MEM :
                        (class_q == CL_JAL || class_q == CL_JALR) ? WB_PC4 : WB_ALU;
            pc_write  = class_q == CL_JAL || class_q == CL_JALR;
            pc_src    = pc_write;
            state_d   = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      if (rst) begin
         imem_req  = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 1'b0;
         branch    = 1'b0;
         reg_write = 1'b0;
         alu_src_a = 2'b00;
         alu_src_b = 2'b00;
         alu_op    = 2'b00;
         wb_sel    = 2'b00;
      end
   end
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: per-cycle scoreboard over a default build and an ext-off/short-timeout build
module tb_riscv_multicycle_ctrl;
   localparam logic [6:0] R = 7'b0110011, L = 7'b0000011, S = 7'b0100011, J = 7'b1101111;
   localparam logic [6:0] B = 7'b1100011, JR = 7'b1100111, AU = 7'b0010111, LU = 7'b0110111;

   logic clk = 1'b0, rst = 1'b1, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic [6:0] opcode = 7'd0;

   logic m_imem_req, m_dmem_req, m_dmem_we, m_ir_write, m_pc_write, m_pc_src, m_branch, m_reg_write, m_ill, m_to;
   logic [1:0] m_a, m_b, m_op, m_wb;
   logic [2:0] m_st;
   logic a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_pc_src, a_branch, a_reg_write, a_ill, a_to;
   logic [1:0] a_a, a_b, a_op, a_wb;
   logic [2:0] a_st;
   logic [20:0] obs_m, obs_a;
   logic [21:0] ent;

   logic [21:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   riscv_multicycle_ctrl u_main (
      .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(m_imem_req), .dmem_req(m_dmem_req), .dmem_we(m_dmem_we), .ir_write(m_ir_write),
      .pc_write(m_pc_write), .pc_src(m_pc_src), .branch(m_branch), .reg_write(m_reg_write),
      .alu_src_a(m_a), .alu_src_b(m_b), .alu_op(m_op), .wb_sel(m_wb),
      .illegal_instr(m_ill), .mem_timeout(m_to), .state_o(m_st)
   );

   riscv_multicycle_ctrl #(.ENABLE_EXT(0), .TIMEOUT_CYCLES(4)) u_alt (
      .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(a_imem_req), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .ir_write(a_ir_write),
      .pc_write(a_pc_write), .pc_src(a_pc_src), .branch(a_branch), .reg_write(a_reg_write),
      .alu_src_a(a_a), .alu_src_b(a_b), .alu_op(a_op), .wb_sel(a_wb),
      .illegal_instr(a_ill), .mem_timeout(a_to), .state_o(a_st)
   );

   assign obs_m = {m_st, m_imem_req, m_dmem_req, m_dmem_we, m_ir_write, m_pc_write, m_pc_src, m_branch,
                   m_reg_write, m_a, m_b, m_op, m_wb, m_ill, m_to};
   assign obs_a = {a_st, a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_pc_src, a_branch,
                   a_reg_write, a_a, a_b, a_op, a_wb, a_ill, a_to};

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b (state|imem dmem we irw pcw pcsrc br regw|a b op wb|ill to)", tag, got, want);
      end
   endtask

   // stb = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, branch, reg_write}, fl = {ill, to}
   function automatic logic [20:0] ex(input logic [2:0] st, input logic [7:0] stb, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op, input logic [1:0] wb,
                                      input logic [1:0] fl);
      return {st, stb, a, b, op, wb, fl};
   endfunction

   task automatic cyc(input logic r, input logic [6:0] op, input logic ir, input logic dr, input logic alt,
                      input string tag, input logic [20:0] want);
      rst = r;
      opcode = op;
      imem_ready = ir;
      dmem_ready = dr;
      exp_q.push_back({alt, want});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_only();
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // pop one expectation per cycle, mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         ent = exp_q.pop_front();
         check(tag_q.pop_front(), ent[21] ? obs_a : obs_m, ent[20:0]);
      end
   end

   initial begin
      logic [20:0] fr, fw, dec, wb1, ex_imm;
      fr     = ex(3'd0, 8'b10011000, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
      fw     = ex(3'd0, 8'b10000000, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
      dec    = ex(3'd1, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      wb1    = ex(3'd4, 8'b00000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      ex_imm = ex(3'd2, 8'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
      @(posedge clk);
      #1;
      cyc(1, R, 1, 1, 0, "reset", ex(3'd0, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, R, 1, 1, 0, "r_fetch", fr);
      cyc(0, R, 1, 1, 0, "r_decode", dec);
      cyc(0, R, 1, 1, 0, "r_exec", ex(3'd2, 8'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0));
      cyc(0, R, 1, 1, 0, "r_wb", wb1);
      cyc(0, R, 1, 1, 0, "r_refetch", fr);
      reset_only();
      cyc(0, L, 1, 0, 0, "ld_fetch", fr);
      cyc(0, L, 1, 0, 0, "ld_decode", dec);
      cyc(0, L, 1, 0, 0, "ld_exec", ex_imm);
      for (int i = 0; i < 3; i++) cyc(0, L, 1, 0, 0, "ld_mem_wait", ex(3'd3, 8'b01000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, L, 1, 1, 0, "ld_mem_ready", ex(3'd3, 8'b01000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, L, 1, 0, 0, "ld_wb", ex(3'd4, 8'b00000001, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0));
      cyc(0, L, 1, 0, 0, "ld_refetch", fr);
      reset_only();
      cyc(0, J, 1, 1, 0, "jal_fetch", fr);
      cyc(0, J, 1, 1, 0, "jal_decode", dec);
      cyc(0, J, 1, 1, 0, "jal_exec", ex(3'd2, 8'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0));
      cyc(0, J, 1, 1, 0, "jal_wb", ex(3'd4, 8'b00001101, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0));
      cyc(0, B, 1, 1, 0, "beq_fetch", fr);
      cyc(0, B, 1, 1, 0, "beq_decode", dec);
      cyc(0, B, 1, 1, 0, "beq_exec", ex(3'd2, 8'b00000010, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0));
      cyc(0, B, 1, 1, 0, "beq_refetch", fr);
      reset_only();
      cyc(0, JR, 1, 1, 0, "jalr_fetch", fr);
      cyc(0, JR, 1, 1, 0, "jalr_decode", dec);
      cyc(0, JR, 1, 1, 0, "jalr_exec", ex_imm);
      cyc(0, JR, 1, 1, 0, "jalr_wb", ex(3'd4, 8'b00001101, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0));
      cyc(0, AU, 1, 1, 0, "auipc_fetch", fr);
      cyc(0, AU, 1, 1, 0, "auipc_decode", dec);
      cyc(0, AU, 1, 1, 0, "auipc_exec", ex(3'd2, 8'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0));
      cyc(0, AU, 1, 1, 0, "auipc_wb", wb1);
      cyc(0, LU, 1, 1, 0, "lui_fetch", fr);
      cyc(0, LU, 1, 1, 0, "lui_decode", dec);
      cyc(0, LU, 1, 1, 0, "lui_exec", ex(3'd2, 8'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0));
      cyc(0, LU, 1, 1, 0, "lui_wb", wb1);
      cyc(0, S, 1, 1, 0, "st_fetch", fr);
      cyc(0, S, 1, 1, 0, "st_decode", dec);
      cyc(0, S, 1, 1, 0, "st_exec", ex_imm);
      cyc(0, S, 1, 1, 0, "st_mem", ex(3'd3, 8'b01100000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, S, 1, 1, 0, "st_refetch", fr);
      reset_only();
      cyc(0, AU, 1, 1, 1, "ill_fetch", fr);
      cyc(0, AU, 1, 1, 1, "ill_decode", dec);
      for (int i = 0; i < 3; i++) cyc(0, AU, 1, 1, 1, "ill_trap", ex(3'd5, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'b10));
      cyc(1, AU, 1, 1, 1, "ill_rst", ex(3'd5, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00));
      cyc(0, AU, 0, 0, 1, "ill_cleared", fw);
      reset_only();
      for (int i = 0; i < 4; i++) cyc(0, R, 0, 0, 1, "to_wait", fw);
      cyc(0, R, 0, 0, 1, "to_trap", ex(3'd5, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'b01));
      cyc(0, R, 1, 1, 1, "to_trap_held", ex(3'd5, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'b01));
      reset_only();
      for (int i = 0; i < 3; i++) cyc(0, R, 0, 0, 1, "to_wait2", fw);
      cyc(0, R, 1, 0, 1, "to_ready_wins", fr);
      cyc(0, R, 1, 0, 1, "to_decode", dec);
      cyc(0, R, 1, 0, 1, "to_exec", ex(3'd2, 8'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0));
      reset_only();
      cyc(0, S, 1, 0, 0, "strst_fetch", fr);
      cyc(0, S, 1, 0, 0, "strst_decode", dec);
      cyc(0, S, 1, 0, 0, "strst_exec", ex_imm);
      cyc(0, S, 0, 0, 0, "strst_mem", ex(3'd3, 8'b01100000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(1, S, 0, 0, 0, "strst_rst", ex(3'd3, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, S, 0, 0, 0, "strst_refetch", fw);
      cyc(0, S, 0, 0, 0, "strst_wait", fw);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB states, handshakes with instruction and data memories that have variable latency, and drives per-state datapath strobes and mux selects. It sits between the shared-memory multi-cycle datapath and the instruction/data memory ports. It adds optional AUIPC/JALR support, illegal-opcode detection and a memory-timeout trap.

## Interface
- `ENABLE_EXT`, default 1: when set, AUIPC (0010111) and JALR (1100111) are legal; when 0, both are illegal.
- `TIMEOUT_CYCLES`, default 16: number of consecutive wait cycles before a trap; 0 disables the timeout.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `imem_ready` in 1: fetch data valid this cycle.
- `dmem_ready` in 1: load data valid, or store accepted, this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: data write enable.
- `ir_write` out 1: capture IR and old_pc.
- `pc_write` out 1: unconditional PC load.
- `pc_src` out 1: PC source, 0 = ALU PC+4, 1 = ALU result.
- `branch` out 1: datapath loads PC if compare taken.
- `reg_write` out 1: register file write.
- `alu_src_a` out 2: 00 rs1, 01 old_pc, 10 zero.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 const 4.
- `alu_op` out 2: 00 add, 01 pass-B, 10 funct-decoded, 11 branch compare.
- `wb_sel` out 2: 00 ALU, 01 mem, 10 PC+4.
- `illegal_instr` out 1: sticky trap flag.
- `mem_timeout` out 1: sticky trap flag.
- `state_o` out 3: current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Reset state is FETCH.
- FETCH
  - Outputs: `imem_req`=1, `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00.
  - On `imem_ready`: `ir_write`=1 and `pc_write`=1 with `pc_src`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Classify the opcode and register the class.
  - Unknown or disabled opcode: go to TRAP and set `illegal_instr`.
  - Otherwise go to EXEC.
- EXEC: one cycle; selects per class.
  - R-type: a=00, b=00, op=10; go to WB.
  - I-ALU: a=00, b=01, op=10; go to WB.
  - Load or store: a=00, b=01, op=00; go to MEM.
  - LUI: a=10, b=01, op=01; go to WB.
  - AUIPC: a=01, b=01, op=00; go to WB.
  - JAL: a=01, b=01, op=00; go to WB.
  - JALR: a=00, b=01, op=00; go to WB.
  - Branch: a=00, b=00, op=11, `branch`=1; go to FETCH.
- MEM
  - `dmem_req`=1 held until `dmem_ready`; `dmem_we`=1 for stores.
  - Load goes to WB; store goes to FETCH.
- WB
  - `reg_write`=1.
  - `wb_sel` is 01 for loads, 10 for JAL/JALR, 00 otherwise.
  - JAL/JALR also assert `pc_write`=1 with `pc_src`=1, using the ALU result registered in EXEC.
  - Go to FETCH.
- TRAP
  - All strobes 0.
  - Flags held until `rst`; no exit other than reset.
- Timeout counter
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on state entry and whenever ready is seen.
  - Increments each FETCH/MEM cycle in which ready is low.
  - If it equals `TIMEOUT_CYCLES-1` and ready is low, go to TRAP and set `mem_timeout`.
  - If ready and the limit coincide, ready wins.

## Timing
- All strobes are Moore-style decodes of state plus the registered class.
- `ir_write` and `pc_write` in FETCH are gated combinationally by `imem_ready`.
- Reset
  - While `rst`=1, every strobe and flag output is forced to 0.
  - The state register, class, counter and flags clear on the edge.
  - The first cycle after `rst` falls is FETCH with `imem_req`=1.
  - Reset mid-MEM drops `dmem_req` in the same cycle.
- Latency with zero-wait memories:
  - Branch: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- Requests stay asserted and stable until the matching ready. Ready while no request is outstanding is ignored.

## Structure
- `riscv_ctrl_pkg` holds:
  - opcode localparams;
  - the state enum (3-bit);
  - the class enum;
  - the `alu_op`, `alu_src_a`, `alu_src_b` and `wb_sel` encodings.
- Sub-module `riscv_opcode_class`: combinational opcode-to-class mapping with a legal flag, taking `ENABLE_EXT`. The FSM and timeout counter stay in the top module.

## Test plan
- R-type: `opcode`=0110011, both readies tied high.
  - State sequence 0,1,2,4,0.
  - `reg_write`=1 only in cycle 4; `alu_op`=10 in EXEC.
- Load: `opcode`=0000011, `dmem_ready` held low for 3 MEM cycles.
  - `dmem_req` high for 4 cycles.
  - WB with `wb_sel`=01; 8 cycles total.
- JAL, then BEQ:
  - JAL: WB asserts `reg_write`, `wb_sel`=10, `pc_write`=1, `pc_src`=1.
  - BEQ: EXEC asserts `branch`=1, `alu_op`=11, and returns to FETCH after 3 cycles.
- Build with `ENABLE_EXT`=0 and drive `opcode`=0010111.
  - DECODE goes to TRAP; `illegal_instr`=1, `state_o`=5.
  - Further readies are ignored.
  - `rst` pulse returns to FETCH and clears the flag.
- `TIMEOUT_CYCLES`=4, `imem_ready` low.
  - `imem_req` high 4 cycles, then TRAP with `mem_timeout`=1.
  - Repeat with `imem_ready` rising on the 4th cycle: DECODE, no trap.
- Assert `rst` during MEM of a store.
  - `dmem_req`/`dmem_we` drop the same cycle.
  - FETCH is entered the cycle after `rst` falls; no `reg_write` is seen.
